// File: rtl/phys_reg_file.sv
// -----------------------------------------------------------------------------
// phys_reg_file
//
// Multi-ported physical register file for the out-of-order core.
// Holds 2^PRN_BITS registers of DATA_BITS each; every PRN is ordinary storage
// (no hardwired-zero register).
//
// Ports
//   clk       : clock, state updates on the rising edge
//   rst       : asynchronous active-high reset, clears all registers
//   op_ren    : [OP_R_PORTS][MAX_OPERANDS] read-lane enables
//   op_rprn   : [OP_R_PORTS][MAX_OPERANDS] read-lane register numbers
//   op_rdata  : [OP_R_PORTS][MAX_OPERANDS] read-lane data (combinational,
//               0 for disabled lanes, bypasses same-cycle writes)
//   op_wen    : [OP_W_PORTS][MAX_OPERANDS] write-lane enables
//   op_wprn   : [OP_W_PORTS][MAX_OPERANDS] write-lane register numbers
//   op_wdata  : [OP_W_PORTS][MAX_OPERANDS] write-lane data
// -----------------------------------------------------------------------------
module phys_reg_file #(
  parameter int OP_R_PORTS   = 4,
  parameter int OP_W_PORTS   = 4,
  parameter int MAX_OPERANDS = 3,
  parameter int PRN_BITS     = 6,
  parameter int DATA_BITS    = 64
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [OP_R_PORTS-1:0][MAX_OPERANDS-1:0]               op_ren,
  input  logic [OP_R_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  op_rprn,
  output logic [OP_R_PORTS-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0] op_rdata,
  input  logic [OP_W_PORTS-1:0][MAX_OPERANDS-1:0]               op_wen,
  input  logic [OP_W_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  op_wprn,
  input  logic [OP_W_PORTS-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0] op_wdata
);

  localparam int NREGS = 1 << PRN_BITS;

  logic [NREGS-1:0][DATA_BITS-1:0] regs_q;
  logic [NREGS-1:0][DATA_BITS-1:0] regs_d;

  // Next-state image of the whole file. Write lanes are applied in ascending
  // flat-index order so the highest-index lane overwrites earlier ones when
  // several target the same PRN. Writes are suppressed while rst is high so
  // that neither the stored state nor the bypass path sees them.
  always_comb begin
    regs_d = regs_q;
    if (!rst) begin
      for (int p = 0; p < OP_W_PORTS; p++) begin
        for (int o = 0; o < MAX_OPERANDS; o++) begin
          if (op_wen[p][o]) begin
            regs_d[op_wprn[p][o]] = op_wdata[p][o];
          end
        end
      end
    end
  end

  // Reading from the next-state image gives same-cycle write bypass with the
  // same winner as the stored result, at no extra priority logic.
  always_comb begin
    op_rdata = '0;
    for (int p = 0; p < OP_R_PORTS; p++) begin
      for (int o = 0; o < MAX_OPERANDS; o++) begin
        if (op_ren[p][o]) begin
          op_rdata[p][o] = regs_d[op_rprn[p][o]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_phys_reg_file.sv
module tb_phys_reg_file;

  localparam int RP = 4;
  localparam int WP = 4;
  localparam int MO = 3;
  localparam int PB = 6;
  localparam int DB = 64;
  localparam int NL = RP * MO;

  logic clk;
  logic rst;
  logic [RP-1:0][MO-1:0]         op_ren;
  logic [RP-1:0][MO-1:0][PB-1:0] op_rprn;
  logic [RP-1:0][MO-1:0][DB-1:0] op_rdata;
  logic [WP-1:0][MO-1:0]         op_wen;
  logic [WP-1:0][MO-1:0][PB-1:0] op_wprn;
  logic [WP-1:0][MO-1:0][DB-1:0] op_wdata;

  int checks;
  int failures;

  phys_reg_file #(
    .OP_R_PORTS(RP), .OP_W_PORTS(WP), .MAX_OPERANDS(MO),
    .PRN_BITS(PB), .DATA_BITS(DB)
  ) dut (
    .clk(clk), .rst(rst),
    .op_ren(op_ren), .op_rprn(op_rprn), .op_rdata(op_rdata),
    .op_wen(op_wen), .op_wprn(op_wprn), .op_wdata(op_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    op_ren   = '0;
    op_rprn  = '0;
    op_wen   = '0;
    op_wprn  = '0;
    op_wdata = '0;
  endtask

  task automatic wlane(input int f, input int prn, input logic [DB-1:0] d);
    op_wen[f / MO][f % MO]   = 1'b1;
    op_wprn[f / MO][f % MO]  = PB'(prn);
    op_wdata[f / MO][f % MO] = d;
  endtask

  task automatic rlane(input int f, input int prn);
    op_ren[f / MO][f % MO]  = 1'b1;
    op_rprn[f / MO][f % MO] = PB'(prn);
  endtask

  function automatic logic [DB-1:0] rd(input int f);
    return op_rdata[f / MO][f % MO];
  endfunction

  // Advance one full cycle: through the rising edge to the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b1;

    // Reads during reset: every PRN on every lane is 0.
    @(negedge clk);
    for (int r = 0; r < 64; r++) begin
      idle();
      for (int f = 0; f < NL; f++) rlane(f, r);
      #1;
      for (int f = 0; f < NL; f++) chk($sformatf("rst_read prn%0d lane%0d", r, f), rd(f), '0);
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // After reset, still 0 on every PRN.
    for (int r = 0; r < 64; r += 7) begin
      idle();
      for (int f = 0; f < NL; f++) rlane(f, (r + f) % 64);
      #1;
      for (int f = 0; f < NL; f++) chk($sformatf("post_rst prn%0d", (r + f) % 64), rd(f), '0);
    end

    // Write PRN 5 from port0 lane0.
    idle();
    wlane(0, 5, 64'hDEADBEEF_CAFEF00D);
    tick();
    idle();
    for (int p = 0; p < RP; p++) rlane(p * MO + 2, 5);
    rlane(0, 6);
    #1;
    for (int p = 0; p < RP; p++) chk($sformatf("wr_rd prn5 port%0d", p), rd(p * MO + 2), 64'hDEADBEEF_CAFEF00D);
    chk("wr_rd prn6", rd(0), '0);

    // Disabled read lanes return 0 even when pointed at a written PRN.
    idle();
    for (int f = 0; f < NL; f++) op_rprn[f / MO][f % MO] = PB'(5);
    #1;
    for (int f = 0; f < NL; f++) chk($sformatf("ren0 lane%0d", f), rd(f), '0);

    // Disabled write lanes have no effect.
    idle();
    op_wprn[1][1]  = PB'(5);
    op_wdata[1][1] = 64'h1234;
    tick();
    idle();
    rlane(4, 5);
    #1;
    chk("wen0 ignored prn5", rd(4), 64'hDEADBEEF_CAFEF00D);

    // Twelve parallel writes to PRN 10..21.
    idle();
    for (int f = 0; f < NL; f++) wlane(f, 10 + f, DB'((10 + f) * 32'h1111));
    tick();
    idle();
    for (int f = 0; f < NL; f++) rlane(f, 21 - f);
    #1;
    for (int f = 0; f < NL; f++) chk($sformatf("par prn%0d", 21 - f), rd(f), DB'((21 - f) * 32'h1111));

    // Conflict on PRN 7: flat 11 beats flat 0.
    idle();
    wlane(0, 7, 64'd1);
    wlane(11, 7, 64'd2);
    tick();
    idle();
    rlane(3, 7);
    #1;
    chk("conflict prn7", rd(3), 64'd2);

    // Bypass on PRN 9.
    idle();
    wlane(5, 9, 64'h55);
    tick();
    idle();
    rlane(6, 9);
    rlane(7, 9);
    #1;
    chk("bypass pre prn9", rd(6), 64'h55);
    wlane(4, 9, 64'hAA);
    wlane(0, 9, 64'h11);
    op_ren[2][1] = 1'b0;
    #1;
    chk("bypass prn9", rd(6), 64'hAA);
    chk("bypass ren0", rd(7), '0);
    tick();
    idle();
    rlane(1, 9);
    #1;
    chk("bypass post prn9", rd(1), 64'hAA);

    // Async reset mid-operation.
    idle();
    wlane(0, 1, 64'h1111_0001);
    wlane(1, 2, 64'h2222_0002);
    wlane(2, 3, 64'h3333_0003);
    tick();
    idle();
    rlane(0, 1); rlane(1, 2); rlane(2, 3);
    #1;
    chk("fill prn1", rd(0), 64'h1111_0001);
    chk("fill prn2", rd(1), 64'h2222_0002);
    chk("fill prn3", rd(2), 64'h3333_0003);
    #1;
    rst = 1'b1;
    wlane(5, 4, 64'h77);
    wlane(6, 1, 64'h99);
    rlane(3, 4);
    #1;
    chk("async rst prn1", rd(0), '0);
    chk("async rst prn2", rd(1), '0);
    chk("async rst prn3", rd(2), '0);
    chk("rst no bypass prn4", rd(3), '0);
    tick();
    rst = 1'b0;
    idle();
    rlane(0, 1); rlane(1, 4); rlane(2, 5);
    #1;
    chk("rst discard prn1", rd(0), '0);
    chk("rst discard prn4", rd(1), '0);
    chk("rst cleared prn5", rd(2), '0);

    // Normal writes resume after reset.
    idle();
    wlane(8, 4, 64'hFEED);
    tick();
    idle();
    rlane(11, 4);
    #1;
    chk("after rst prn4", rd(11), 64'hFEED);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phys_reg_file.md
Name: phys_reg_file

Overview:
- Multi-ported physical register file (PRF) for the out-of-order core.
- Holds 2^PRN_BITS 64-bit physical registers.
- Functional units read source operands through read ports and write results through write ports.
- Each port group carries MAX_OPERANDS lanes, indexed [port][operand].

Parameters:
- OP_R_PORTS, 4, number of read port groups (one per functional unit).
- OP_W_PORTS, 4, number of write port groups (one per functional unit).
- MAX_OPERANDS, 3, lanes per port group.
- PRN_BITS, 6, physical register number width; register count = 2^PRN_BITS = 64.
- DATA_BITS, 64, register width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_ren  in  1 x [OP_R_PORTS][MAX_OPERANDS]  read-lane enable.
- op_rprn  in  PRN_BITS x [OP_R_PORTS][MAX_OPERANDS]  read-lane register number.
- op_rdata  out  DATA_BITS x [OP_R_PORTS][MAX_OPERANDS]  read-lane data.
- op_wen  in  1 x [OP_W_PORTS][MAX_OPERANDS]  write-lane enable.
- op_wprn  in  PRN_BITS x [OP_W_PORTS][MAX_OPERANDS]  write-lane register number.
- op_wdata  in  DATA_BITS x [OP_W_PORTS][MAX_OPERANDS]  write-lane data.

Behaviour:
- Storage: 2^PRN_BITS registers of DATA_BITS each. There is no hardwired-zero register; every PRN is an ordinary storage location.
- Reset:
  - rst high clears every register to 0 immediately, without waiting for a clock edge.
  - While rst is high, writes are ignored.
  - op_rdata follows the read rules below, so enabled lanes return 0 during and after reset until a register is written.
- Read:
  - Combinational, zero latency.
  - For each lane with op_ren=1: op_rdata = current contents of register op_rprn.
  - For each lane with op_ren=0: op_rdata = 0.
  - Reads have no side effects.
  - Any number of lanes may read the same PRN simultaneously.
- Write:
  - On the rising clk edge, every lane with op_wen=1 stores op_wdata into register op_wprn.
  - Lanes with op_wen=0 are ignored regardless of their prn/data values.
- Write conflict: when several enabled lanes target the same PRN in one cycle, the lane with the highest flat index (port*MAX_OPERANDS + operand) wins. All other registers written that cycle still update.
- Read/write same cycle, same PRN:
  - The read is bypassed: op_rdata returns the op_wdata being written that cycle, not the old contents.
  - When several writers target that PRN, the bypass returns the winning writer's data (same priority rule as above).
  - Bypass applies only when both op_ren and op_wen are asserted.
- Write visibility: after the clock edge, the written value is visible combinationally to all read lanes.
- No handshakes, no stalls, no backpressure. Every enabled lane completes in its cycle.
- Register contents persist indefinitely until rewritten or reset.

Test Plan:
- Reset, then read PRN 0..63 on every lane with op_ren=1 -> all op_rdata = 0. With op_ren=0 -> 0 regardless of op_rprn.
- Write-then-read:
  - Port0 lane0 writes PRN 5 = 0xDEADBEEF_CAFEF00D at an edge.
  - Next cycle, ports 0-3 lane 2 read PRN 5 -> all return 0xDEADBEEF_CAFEF00D.
  - PRN 6 still reads 0.
- Parallel writes:
  - In one edge, 12 lanes write distinct PRNs 10..21 with data = PRN*0x1111.
  - Next cycle, each PRN reads back its own value.
- Conflict: in the same cycle, port0 lane0 writes PRN 7 = 1 and port3 lane2 writes PRN 7 = 2 -> PRN 7 reads 2 afterwards.
- Bypass:
  - PRN 9 holds 0x55.
  - In the same cycle, port1 lane1 writes PRN 9 = 0xAA while port2 lane0 reads PRN 9 -> op_rdata = 0xAA combinationally that cycle.
  - PRN 9 reads 0xAA afterwards.
- Async reset mid-operation:
  - Fill PRN 1..3 with nonzero values.
  - Pulse rst between clock edges -> reads return 0 before the next edge.
  - A write enabled in the cycle rst is high is discarded.
